// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if
// Byte handshake between a producer and the buffered UART transmitter.
//   data_i  : byte to transmit (producer -> transmitter)
//   valid_i : data_i holds a byte to send (producer -> transmitter)
//   ready_o : transmitter FIFO has room (transmitter -> producer)
// The transfer happens on a rising clk edge where valid_i && ready_o.
// Modports:
//   master : producer side (core response path)
//   slave  : transmitter side
interface uart_tx_buffered_if;
   logic [7:0] data_i;
   logic       valid_i;
   logic       ready_o;

   modport master (
      output data_i,
      output valid_i,
      input  ready_o
   );

   modport slave (
      input  data_i,
      input  valid_i,
      output ready_o
   );
endinterface

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// 8N1 UART transmitter fed by a small byte FIFO. Bytes arrive over a
// valid/ready handshake and leave on tx as 1 start bit, 8 data bits
// (LSB first) and 1 stop bit. Queued bytes go out as contiguous frames
// with no idle time between a stop bit and the next start bit.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : handshake interface (data_i, valid_i in; ready_o out, = !full)
//   tx     : serial line, registered, idles high
//   busy_o : high while a frame is on the wire or bytes are still queued
// Parameters:
//   CLOCKS_PER_BAUD : clk cycles per bit, >= 2
//   FIFO_DEPTH      : byte entries, power of two, >= 2
module uart_tx_buffered #(
   parameter int CLOCKS_PER_BAUD = 868,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_buffered_if.slave  bus,
   output logic               tx,
   output logic               busy_o
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W  = ADDR_W + 1;
   localparam int CNT_W  = $clog2(CLOCKS_PER_BAUD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic [7:0]       head;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       bit_q;
   logic [2:0]       bit_d;
   logic [7:0]       shift_q;
   logic [7:0]       shift_d;
   logic             tx_d;
   logic             baud_done;

   // The pointers carry one extra MSB: equal pointers mean empty, pointers
   // that differ only in that MSB mean full.
   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign bus.ready_o = !full;
   assign push        = bus.valid_i && !full;
   assign head        = mem[rd_ptr[ADDR_W-1:0]];
   assign baud_done   = (cnt_q == CNT_LAST);

   // Both terms come straight from registers, so busy_o cannot glitch
   // relative to clk.
   assign busy_o = (state_q != IDLE) || !empty;

   // FIFO storage. Contents need no reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[ADDR_W-1:0]] <= bus.data_i;
      end
   end

   // FIFO pointers. A push and a pop on the same edge both advance, so
   // occupancy is unchanged. Pointers wrap naturally at 2*FIFO_DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Serialiser state register. Reset drives tx high at once, which aborts
   // any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx      <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx      <= tx_d;
      end
   end

   // Next-state logic. tx is registered, so every line change is decided
   // one cycle early: the cycle that ends a bit loads the next bit's level.
   // Leaving STOP with bytes queued pops straight into START, which keeps
   // consecutive frames exactly 10 bit times apart.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx;
      pop     = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            tx_d  = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               tx_d    = 1'b0;
               state_d = START;
            end
         end

         START: begin
            cnt_d = baud_done ? '0 : cnt_q + CNT_W'(1);
            if (baud_done) begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               state_d = DATA;
            end
         end

         DATA: begin
            cnt_d = baud_done ? '0 : cnt_q + CNT_W'(1);
            if (baud_done) begin
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end
         end

         STOP: begin
            cnt_d = baud_done ? '0 : cnt_q + CNT_W'(1);
            if (baud_done) begin
               bit_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered
// Self-checking bench for uart_tx_buffered with CLOCKS_PER_BAUD=4 and
// FIFO_DEPTH=4. A queue-based frame model predicts tx, busy_o and ready_o
// every cycle; a small serial receiver decodes tx back into bytes; directed
// scenarios add hand-computed literal expectations, and a random phase
// finishes the run.
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic clk;
   logic rst_n;
   logic tx;
   logic busy_o;

   uart_tx_buffered_if bus ();

   uart_tx_buffered #(
      .CLOCKS_PER_BAUD (CPB),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .tx     (tx),
      .busy_o (busy_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit cmp_en = 0;

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: after rising edge k, cyc == k.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                  name, actual, expected, cyc);
      end
   endtask

   task automatic reportTimeout(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out, got no completion, expected completion", name);
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: a byte queue plus "which frame, how far in".
   // A frame is FRAME cycles long; bit slot = position / CPB, where slot 0
   // is the start bit, slots 1..8 the data LSB first and slot 9 the stop bit.
   // ------------------------------------------------------------------
   logic [7:0] mq[$];
   logic [7:0] acc_log[$];
   bit         m_active;
   int         m_pos;
   logic [7:0] m_cur;
   bit         m_acc;
   logic [7:0] m_data;

   initial begin
      m_active = 0;
      m_pos    = 0;
      m_cur    = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_active = 0;
            m_pos    = 0;
         end else begin
            m_acc  = bus.valid_i && (mq.size() < DEPTH);
            m_data = bus.data_i;
            if (m_active && m_pos != FRAME - 1) begin
               m_pos++;
            end else if (mq.size() != 0) begin
               m_cur    = mq.pop_front();
               m_active = 1;
               m_pos    = 0;
            end else begin
               m_active = 0;
            end
            if (m_acc) begin
               mq.push_back(m_data);
               acc_log.push_back(m_data);
            end
         end
      end
   end

   function automatic logic expTx();
      int slot;
      if (!m_active) return 1'b1;
      slot = m_pos / CPB;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return m_cur[slot - 1];
   endfunction

   // Per-cycle comparison of every output against the model.
   initial forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
         checkOutput("tx", 32'(tx), 32'(expTx()));
         checkOutput("busy_o", 32'(busy_o), 32'(m_active || (mq.size() != 0)));
         checkOutput("ready_o", 32'(bus.ready_o), 32'(mq.size() < DEPTH));
      end
   end

   // ------------------------------------------------------------------
   // Serial receiver: finds a falling edge on tx, samples each bit in
   // the middle of its slot and logs the byte and the start cycle.
   // ------------------------------------------------------------------
   int         rx_cnt = -1;
   logic [7:0] rx_byte;
   logic [7:0] rx_q[$];
   int         rx_starts[$];

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         rx_cnt = -1;
      end else if (rx_cnt < 0) begin
         if (tx == 1'b0) begin
            rx_cnt = 0;
            rx_starts.push_back(cyc);
         end
      end else begin
         rx_cnt++;
         for (int i = 0; i < 8; i++) begin
            if (rx_cnt == CPB * (i + 1) + CPB / 2) rx_byte[i] = tx;
         end
         if (rx_cnt == 9 * CPB + CPB / 2) begin
            checkOutput("rx_stop_bit", 32'(tx), 32'd1);
            rx_q.push_back(rx_byte);
         end
         if (rx_cnt == FRAME - 1) rx_cnt = -1;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers. All are entered and left on a falling edge.
   // ------------------------------------------------------------------
   int acc_cycles[$];

   // Present each byte and hold it until accepted, recording the accept edge.
   task automatic applyStimulus(input logic [7:0] bytes[$]);
      bit acc;
      int n;
      acc_cycles.delete();
      foreach (bytes[i]) begin
         bus.valid_i = 1'b1;
         bus.data_i  = bytes[i];
         n = 0;
         do begin
            acc = bus.ready_o;
            @(negedge clk);
            n++;
         end while (!acc && n < 200);
         if (acc) acc_cycles.push_back(cyc);
         else reportTimeout("push_accept");
      end
      bus.valid_i = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy_o && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy_o) reportTimeout("drain");
      repeat (2) @(negedge clk);
   endtask

   task automatic checkRx(input string name, input logic [7:0] exp[$]);
      checkOutput({name, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
         checkOutput($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp[i]));
      end
   endtask

   task automatic clearLogs();
      rx_q.delete();
      rx_starts.delete();
      acc_log.delete();
   endtask

   // Overall time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // ------------------------------------------------------------------
   // Directed scenarios, then randomized traffic.
   // ------------------------------------------------------------------
   initial begin
      logic a5_bits[8];
      int   n0;
      int   exp_bit;

      a5_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      rst_n       = 1'b0;
      bus.valid_i = 1'b0;
      bus.data_i  = 8'h00;

      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("reset_tx", 32'(tx), 32'd1);
      checkOutput("reset_ready", 32'(bus.ready_o), 32'd1);
      checkOutput("reset_busy", 32'(busy_o), 32'd0);
      rst_n  = 1'b1;
      cmp_en = 1;
      repeat (2) @(negedge clk);

      // Single byte 0xA5: start bit on edges N+1..N+4, data from N+5,
      // stop from N+37, idle after N+41.
      $display("[TB] single byte 0xA5");
      clearLogs();
      applyStimulus('{8'hA5});
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k <= 4) exp_bit = 0;
         else if (k <= 36) exp_bit = int'(a5_bits[(k - 5) / 4]);
         else exp_bit = 1;
         checkOutput($sformatf("a5_tx_k%0d", k), 32'(tx), 32'(exp_bit));
      end
      checkOutput("a5_busy_in_stop", 32'(busy_o), 32'd1);
      @(negedge clk);
      checkOutput("a5_busy_after", 32'(busy_o), 32'd0);
      waitIdle();
      checkRx("a5_rx", '{8'hA5});

      // Three back-to-back bytes form contiguous frames 40 cycles apart.
      $display("[TB] burst 0x00 0xFF 0x55");
      clearLogs();
      applyStimulus('{8'h00, 8'hFF, 8'h55});
      n0 = acc_cycles[0];
      waitIdle();
      checkRx("burst_rx", '{8'h00, 8'hFF, 8'h55});
      if (rx_starts.size() == 3) begin
         checkOutput("burst_latency", 32'(rx_starts[0] - n0), 32'd1);
         checkOutput("burst_gap1", 32'(rx_starts[1] - rx_starts[0]), 32'd40);
         checkOutput("burst_gap2", 32'(rx_starts[2] - rx_starts[1]), 32'd40);
      end else begin
         checkOutput("burst_starts", 32'(rx_starts.size()), 32'd3);
      end

      // Six bytes: five fill the FIFO, the sixth waits for the first pop
      // after frame one's stop bit (accepted 42 edges after the first).
      $display("[TB] fill FIFO with held sixth byte");
      clearLogs();
      applyStimulus('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
      if (acc_cycles.size() == 6) begin
         checkOutput("fill_fifth_accept", 32'(acc_cycles[4] - acc_cycles[0]), 32'd4);
         checkOutput("fill_sixth_accept", 32'(acc_cycles[5] - acc_cycles[0]), 32'd42);
      end
      waitIdle();
      checkRx("fill_rx", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});

      // Push landing on the STOP->START edge with 2 queued: occupancy holds
      // at 2, so two more pushes fill exactly to 4.
      $display("[TB] push/pop at frame boundary");
      clearLogs();
      applyStimulus('{8'hA1, 8'hB2, 8'hC3});
      n0 = acc_cycles[0];
      while (cyc < n0 + 40) @(negedge clk);
      applyStimulus('{8'hD4, 8'hE5, 8'hF6});
      if (acc_cycles.size() == 3) begin
         checkOutput("pp_accept0", 32'(acc_cycles[0] - n0), 32'd41);
         checkOutput("pp_accept2", 32'(acc_cycles[2] - n0), 32'd43);
      end
      checkOutput("pp_ready_full", 32'(bus.ready_o), 32'd0);
      waitIdle();
      checkRx("pp_rx", '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6});

      // Asynchronous reset in the middle of 0x3C's data bits.
      $display("[TB] reset mid-frame");
      clearLogs();
      applyStimulus('{8'h3C, 8'h5A, 8'hC3});
      n0 = acc_cycles[0];
      while (cyc < n0 + 15) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_tx", 32'(tx), 32'd1);
      checkOutput("rst_ready", 32'(bus.ready_o), 32'd1);
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clearLogs();
      repeat (50) @(negedge clk);
      checkOutput("rst_no_residual", 32'(rx_starts.size()), 32'd0);
      checkOutput("rst_idle_busy", 32'(busy_o), 32'd0);
      applyStimulus('{8'h81});
      waitIdle();
      checkRx("rst_rx", '{8'h81});

      // valid_i pulsed with 0xEE while full must be ignored.
      $display("[TB] push while full");
      clearLogs();
      applyStimulus('{8'h10, 8'h20, 8'h30, 8'h40, 8'h50});
      checkOutput("full_ready", 32'(bus.ready_o), 32'd0);
      bus.valid_i = 1'b1;
      bus.data_i  = 8'hEE;
      @(negedge clk);
      bus.valid_i = 1'b0;
      bus.data_i  = 8'h00;
      waitIdle();
      checkRx("full_rx", '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50});

      // Random traffic with a push rate that changes every 200 cycles.
      $display("[TB] random traffic");
      clearLogs();
      for (int blk = 0; blk < 8; blk++) begin
         int rate;
         rate = int'($urandom_range(1, 6));
         repeat (200) begin
            bus.valid_i = ($urandom_range(0, rate) == 0);
            bus.data_i  = 8'($urandom);
            @(negedge clk);
         end
      end
      bus.valid_i = 1'b0;
      waitIdle();
      checkRx("rand_rx", acc_log);

      cmp_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
